// File: rtl/shift_sched.sv
// shift_sched: two-requester round-robin front end feeding a single serial
// shifter. One bit position is shifted per clock, and the result is held
// until the consumer takes it.
module shift_sched #(
  parameter int WIDTH = 9,
  parameter int AMTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [AMTW-1:0]  req_amt0,
  input  logic [AMTW-1:0]  req_amt1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int CMPW = (AMTW > CNTW) ? AMTW : CNTW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_op;
  logic             r_id;
  logic [CNTW-1:0]  r_cnt;
  logic             r_last;

  logic             w_grant_id;
  logic             w_accept;
  logic [1:0]       w_op_sel;
  logic [WIDTH-1:0] w_data_sel;
  logic [AMTW-1:0]  w_amt_sel;
  logic [CMPW-1:0]  w_amt_ext;
  logic [CNTW-1:0]  w_cnt_init;

  // One serial step; << and <<< are identical for a left shift.
  function automatic logic [WIDTH-1:0] shift_step(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] d);
    logic signed [WIDTH-1:0] s;
    s = d;
    case (op)
      2'b01:   shift_step = d >> 1;
      2'b11:   shift_step = s >>> 1;
      default: shift_step = d << 1;
    endcase
  endfunction

  // Grant selection, operand mux and amount clamp to WIDTH.
  always_comb begin
    w_grant_id = 1'b0;
    case (req_valid)
      2'b01:   w_grant_id = 1'b0;
      2'b10:   w_grant_id = 1'b1;
      2'b11:   w_grant_id = ~r_last;
      default: w_grant_id = 1'b0;
    endcase
    w_accept   = (r_state == S_IDLE) && !reset && (req_valid != 2'b00);
    w_op_sel   = w_grant_id ? req_op1   : req_op0;
    w_data_sel = w_grant_id ? req_data1 : req_data0;
    w_amt_sel  = w_grant_id ? req_amt1  : req_amt0;
    w_amt_ext  = CMPW'(w_amt_sel);
    if (w_amt_ext >= CMPW'(WIDTH)) begin
      w_cnt_init = CNTW'(WIDTH);
    end else begin
      w_cnt_init = CNTW'(w_amt_ext);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a zero count still spends one cycle in SHIFT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)        w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == '0)     w_state_nxt = S_DONE;
      S_DONE:  if (rsp_ready)       w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    req_ready = 2'b00;
    if ((r_state == S_IDLE) && !reset && (req_valid != 2'b00)) begin
      req_ready = w_grant_id ? 2'b10 : 2'b01;
    end
    rsp_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  // Operand capture on acceptance, then one shift per cycle until count is 0.
  // The pointer resets to "last granted = 1" so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_op   <= 2'b00;
      r_id   <= 1'b0;
      r_cnt  <= '0;
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_data <= w_data_sel;
      r_op   <= w_op_sel;
      r_id   <= w_grant_id;
      r_cnt  <= w_cnt_init;
      r_last <= w_grant_id;
    end else if ((r_state == S_SHIFT) && (r_cnt != '0)) begin
      r_data <= shift_step(r_op, r_data);
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign rsp_data = r_data;
  assign rsp_id   = r_id;

endmodule

// File: tb/tb_shift_sched.sv
// Testbench for shift_sched: directed vector table, contention and
// reset corner cases, then randomized transactions against a reference model.
module tb_shift_sched;
  localparam int W  = 9;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_op0, req_op1;
  logic [W-1:0]  req_data0, req_data1;
  logic [AW-1:0] req_amt0, req_amt1;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [W-1:0]  rsp_data;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int m_last;          // model: last granted requester
  longint t_acc;       // time of most recent acceptance edge
  longint t_prev;

  always #5 clk = ~clk;

  shift_sched #(.WIDTH(W), .AMTW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_amt0(req_amt0), .req_amt1(req_amt1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  typedef struct {
    logic [1:0]    vmask;
    logic [1:0]    op;
    logic [W-1:0]  data;
    logic [AW-1:0] amt;
    int            bp;
    logic          exp_id;
    logic [W-1:0]  exp_data;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole shift by the full amount, letting the language saturate.
  function automatic logic [W-1:0] ref_shift(input logic [1:0] op, input logic [W-1:0] d,
                                             input int amt);
    logic signed [W-1:0] s;
    s = d;
    if (op == 2'b11) return s >>> amt;
    if (op == 2'b01) return d >> amt;
    return d << amt;
  endfunction

  function automatic int model_grant(input logic [1:0] vmask);
    if (vmask == 2'b01) return 0;
    if (vmask == 2'b10) return 1;
    return (m_last == 0) ? 1 : 0;
  endfunction

  // Called just after a negedge with the DUT in IDLE; returns likewise.
  task automatic txn(input logic [1:0] vmask,
                     input logic [1:0] op0, input logic [1:0] op1,
                     input logic [W-1:0] d0, input logic [W-1:0] d1,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input int bp, input logic keep,
                     input logic exp_id, input logic [W-1:0] exp_data,
                     output int n);
    int g;
    req_valid = vmask;
    req_op0 = op0;  req_op1 = op1;
    req_data0 = d0; req_data1 = d1;
    req_amt0 = a0;  req_amt1 = a1;
    rsp_ready = (bp == 0);
    #1;
    g = model_grant(vmask);
    chk("grant", 32'(req_ready), 32'(1) << g);
    chk("idle_busy", 32'(busy), 32'd0);
    n = (g == 1) ? int'(a1) : int'(a0);
    if (n > W) n = W;
    @(posedge clk);
    t_prev = t_acc;
    t_acc  = $time;
    m_last = g;
    @(negedge clk);
    req_op0 = 2'($urandom); req_op1 = 2'($urandom);
    req_data0 = W'($urandom); req_data1 = W'($urandom);
    req_amt0 = AW'($urandom); req_amt1 = AW'($urandom);
    req_valid = keep ? vmask : 2'b00;
    #1;
    for (int j = 0; j <= n; j++) begin
      if (j > 0) begin
        @(negedge clk);
        #1;
      end
      chk("shift_valid", 32'(rsp_valid), 32'd0);
      chk("shift_ready", 32'(req_ready), 32'd0);
      chk("shift_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(exp_data));
    chk("rsp_id", 32'(rsp_id), 32'(exp_id));
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'(exp_data));
      chk("hold_id", 32'(rsp_id), 32'(exp_id));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("back_idle_valid", 32'(rsp_valid), 32'd0);
    chk("back_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, nprev, g;
    logic [1:0] vm, o0, o1;
    logic [W-1:0] d0, d1;
    logic [AW-1:0] a0, a1;
    logic [W-1:0] ed;

    tbl[0] = '{2'b01, 2'b00, 9'h0FF, 4'd3,  0, 1'b0, 9'h1F8};
    tbl[1] = '{2'b10, 2'b11, 9'h100, 4'd15, 0, 1'b1, 9'h1FF};
    tbl[2] = '{2'b01, 2'b01, 9'h155, 4'd0,  5, 1'b0, 9'h155};
    tbl[3] = '{2'b10, 2'b10, 9'h0A5, 4'd4,  0, 1'b1, 9'h050};
    tbl[4] = '{2'b01, 2'b01, 9'h1AB, 4'd9,  1, 1'b0, 9'h000};
    tbl[5] = '{2'b10, 2'b11, 9'h0FF, 4'd2,  0, 1'b1, 9'h03F};
    tbl[6] = '{2'b01, 2'b11, 9'h1C0, 4'd3,  2, 1'b0, 9'h1F8};
    tbl[7] = '{2'b10, 2'b00, 9'h1FF, 4'd12, 0, 1'b1, 9'h000};
    tbl[8] = '{2'b01, 2'b10, 9'h001, 4'd8,  0, 1'b0, 9'h100};
    tbl[9] = '{2'b10, 2'b01, 9'h1FF, 4'd1,  3, 1'b1, 9'h0FF};

    reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    req_op0 = '0; req_op1 = '0; req_data0 = '0; req_data1 = '0;
    req_amt0 = '0; req_amt1 = '0;
    t_acc = 0; t_prev = 0; m_last = 1;

    // Reset state, with requests pending while reset is high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    reset = 1'b0; req_valid = 2'b00;
    @(negedge clk);
    #1;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].vmask == 2'b01)
        txn(tbl[i].vmask, tbl[i].op, 2'($urandom), tbl[i].data, W'($urandom),
            tbl[i].amt, AW'($urandom), tbl[i].bp, 1'b0, tbl[i].exp_id, tbl[i].exp_data, n);
      else
        txn(tbl[i].vmask, 2'($urandom), tbl[i].op, W'($urandom), tbl[i].data,
            AW'($urandom), tbl[i].amt, tbl[i].bp, 1'b0, tbl[i].exp_id, tbl[i].exp_data, n);
    end

    // Contention: both valid continuously, rsp_ready high; grants alternate.
    nprev = 0;
    for (int i = 0; i < 4; i++) begin
      a0 = AW'(i + 1); a1 = AW'(i + 2);
      d0 = 9'h0F0 + W'(i); d1 = 9'h10F - W'(i);
      ed = (i % 2 == 0) ? ref_shift(2'b01, d0, int'(a0)) : ref_shift(2'b11, d1, int'(a1));
      txn(2'b11, 2'b01, 2'b11, d0, d1, a0, a1, 0, 1'b1, 1'(i % 2), ed, n);
      if (i > 0) chk("spacing", 32'((t_acc - t_prev) / 10), 32'(3 + nprev));
      nprev = n;
    end
    req_valid = 2'b00;

    // Reset in the middle of a SHIFT: operation dropped, requester 0 favoured.
    req_valid = 2'b10; req_op1 = 2'b00; req_data1 = 9'h0AB; req_amt1 = 4'd8;
    rsp_ready = 1'b1;
    #1;
    chk("mid_grant", 32'(req_ready), 32'd2);
    @(posedge clk);
    m_last = 1;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1; req_valid = 2'b11;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_data", 32'(rsp_data), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    reset = 1'b0; req_valid = 2'b00;
    m_last = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
    end
    txn(2'b11, 2'b00, 2'b00, 9'h003, 9'h005, 4'd1, 4'd1, 0, 1'b0, 1'b0, 9'h006, n);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 30; i++) begin
      vm = 2'($urandom_range(1, 3));
      o0 = 2'($urandom); o1 = 2'($urandom);
      d0 = W'($urandom); d1 = W'($urandom);
      a0 = AW'($urandom); a1 = AW'($urandom);
      g = model_grant(vm);
      ed = (g == 1) ? ref_shift(o1, d1, int'(a1)) : ref_shift(o0, d0, int'(a0));
      txn(vm, o0, o1, d0, d1, a0, a1, $urandom_range(0, 3), 1'($urandom), 1'(g), ed, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 The module SHALL have parameter WIDTH, default 9, giving the operand and result width in bits.
REQ-002 The module SHALL have parameter AMTW, default 4, giving the shift-amount width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset that is synchronous and active-high.
REQ-005 The module SHALL have port req_valid, input, 2 bits: per-requester request valid; bit i belongs to requester i.
REQ-006 The module SHALL have port req_ready, output, 2 bits: per-requester accept.
REQ-007 The module SHALL have ports req_op0 and req_op1, input, 2 bits each: operation code; 00 = <<, 01 = >>, 10 = <<<, 11 = >>>.
REQ-008 The module SHALL have ports req_data0 and req_data1, input, WIDTH bits each: operand.
REQ-009 The module SHALL have ports req_amt0 and req_amt1, input, AMTW bits each: shift amount, unsigned.
REQ-010 The module SHALL have port rsp_valid, output, 1 bit: result available.
REQ-011 The module SHALL have port rsp_ready, input, 1 bit: consumer accepts result.
REQ-012 The module SHALL have port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-013 The module SHALL have port rsp_data, output, WIDTH bits: shifted result.
REQ-014 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 The module SHALL implement the states IDLE, SHIFT and DONE, which share one serial 1-bit-per-cycle shift register.
REQ-016 IDLE: req_ready SHALL be one-hot on the granted requester, or 0 when no req_valid bit is set; req_ready SHALL be 0 in every other state.
REQ-017 Grant rule: if only one req_valid bit is set, that requester SHALL be granted; if both are set, the requester not granted last SHALL win, which is round-robin.
REQ-018 Acceptance occurs when req_valid[g] and req_ready[g] are both high; the round-robin pointer SHALL update only on acceptance.
REQ-019 On acceptance the module SHALL latch the operand, opcode and requester id, set the count to min(amt, WIDTH), and move to SHIFT.
REQ-020 SHIFT, count > 0, the per-cycle step SHALL be:
- op 00 or 10: shift left by 1, with 0 entering the LSB.
- op 01: shift right by 1, with 0 entering the MSB.
- op 11: shift right by 1, with the MSB replicated.
- The count SHALL decrement by 1.
REQ-021 SHIFT, count == 0: the module SHALL move to DONE without modifying the data, so an amount of 0 costs one cycle in SHIFT.
REQ-022 Latency: if acceptance is on edge T, rsp_valid SHALL be high after edge T + 1 + min(amt, WIDTH).
REQ-023 Amounts >= WIDTH SHALL saturate: << and >> give all zeros, >>> gives all copies of the sign bit, and <<< gives the same result as <<.
REQ-024 DONE: rsp_valid SHALL be 1; rsp_data and rsp_id SHALL stay stable until rsp_ready is high.
REQ-025 Leaving DONE: when rsp_ready is high, the module SHALL return to IDLE on that edge.
- The next request SHALL NOT be accepted in the same cycle; the minimum spacing between acceptances is 3 cycles.
REQ-026 rsp_data SHALL show the internal shift register in every state; consumers SHALL sample it only when rsp_valid is high.
REQ-027 Changes on req_* inputs after acceptance SHALL NOT affect the operation in flight.
REQ-028 When rsp_ready is held low the module SHALL stay in DONE indefinitely; req_ready SHALL remain 0 on both bits.

Reset
REQ-029 While reset is high at a clock edge, on that edge:
- The state SHALL become IDLE.
- rsp_valid, busy, rsp_id, rsp_data and the count SHALL become 0.
- The round-robin pointer SHALL favour requester 0.
REQ-030 Reset SHALL override all other activity, including a SHIFT or DONE in progress; the operation in flight SHALL be discarded with no response.
REQ-031 In the cycle reset is high, req_ready SHALL be 0.

Verification
REQ-032 Logical left shift: requester 0, op 00, data 9'h0FF, amt 3 -> rsp_valid high 4 cycles after acceptance, rsp_data 9'h1F8, rsp_id 0.
REQ-033 Arithmetic right shift with saturation: requester 1, op 11, data 9'h100, amt 15 -> rsp_data 9'h1FF after 10 cycles, since the count is clamped to 9.
REQ-034 Contention: both requesters valid every cycle, rsp_ready tied high -> grants alternate 0,1,0,1 and acceptances are 3 + amt cycles apart.
REQ-035 Zero amount and back-pressure: op 01, amt 0, data 9'h155, rsp_ready low for 5 cycles -> rsp_data 9'h155 held stable and req_ready 0 throughout.
REQ-036 Reset mid-operation: assert reset while in SHIFT with amt 8 -> next cycle IDLE, rsp_valid 0, no response ever issued, and the next grant goes to requester 0.
